// File: rtl/reg_file_mp.sv
// Multi-port register file: NRD combinational reads, two write ports, busy scoreboard, registered debug read.
// Define RF_BYPASS_EN to forward same-cycle write data and busy clears to the read ports.
module reg_file_mp #(
  parameter int XLEN = 32,
  parameter int AW   = 5,
  parameter int NRD  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NRD*AW-1:0]    ra,
  output logic [NRD*XLEN-1:0]  rd,
  output logic [NRD-1:0]       rbusy,
  input  logic                 we0,
  input  logic [AW-1:0]        wa0,
  input  logic [XLEN-1:0]      wd0,
  input  logic                 we1,
  input  logic [AW-1:0]        wa1,
  input  logic [XLEN-1:0]      wd1,
  input  logic                 set_en,
  input  logic [AW-1:0]        set_addr,
  input  logic [AW-1:0]        dbg_addr,
  output logic [XLEN-1:0]      dbg_data
);

  localparam int NREG = 2**AW;

  logic [XLEN-1:0] r_rf [NREG];
  logic [NREG-1:0] r_busy;
  logic [XLEN-1:0] r_dbg_data;

  logic            w_wr0;
  logic            w_wr1;
  logic            w_set;
  logic [NREG-1:0] w_busy_nxt;

  // Address 0 is hardwired: writes and sets aimed at it never take effect.
  assign w_wr0 = !rst && we0 && (wa0 != '0);
  assign w_wr1 = !rst && we1 && (wa1 != '0);
  assign w_set = !rst && set_en && (set_addr != '0);

  always_comb begin
    w_busy_nxt = r_busy;
    if (w_wr0) w_busy_nxt[wa0] = 1'b0;
    if (w_wr1) w_busy_nxt[wa1] = 1'b0;
    if (w_set) w_busy_nxt[set_addr] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) r_rf[i] <= '0;
      r_busy     <= '0;
      r_dbg_data <= '0;
    end else begin
      // Port 1 is assigned last so it wins an address collision.
      if (w_wr0) r_rf[wa0] <= wd0;
      if (w_wr1) r_rf[wa1] <= wd1;
      r_busy     <= w_busy_nxt;
      r_dbg_data <= (dbg_addr == '0) ? '0 : r_rf[dbg_addr];
    end
  end

  assign dbg_data = r_dbg_data;

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]   w_ra;
    logic [XLEN-1:0] w_rd;
    logic            w_busy;

    assign w_ra = ra[k*AW +: AW];

    always_comb begin
      w_rd   = (w_ra == '0) ? '0 : r_rf[w_ra];
      w_busy = (w_ra == '0) ? 1'b0 : r_busy[w_ra];
`ifdef RF_BYPASS_EN
      if ((w_wr0 && (wa0 == w_ra)) || (w_wr1 && (wa1 == w_ra))) begin
        w_busy = w_busy_nxt[w_ra];
        w_rd   = (w_wr1 && (wa1 == w_ra)) ? wd1 : wd0;
      end
`endif
    end

    assign rd[k*XLEN +: XLEN] = w_rd;
    assign rbusy[k]           = w_busy;
  end

endmodule

// File: doc/reg_file_mp.md
REG_FILE_MP -- requirements
Module: reg_file_mp

Interface
REQ-001 Parameter XLEN, default 32, data width in bits.
REQ-002 Parameter AW, default 5, address width; register count NREG = 2**AW.
REQ-003 Parameter NRD, default 2, number of combinational read ports (1..4).
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 ra  in  NRD*AW  packed read addresses; port k = bits [k*AW +: AW].
REQ-007 rd  out  NRD*XLEN  packed read data, port k = bits [k*XLEN +: XLEN].
REQ-008 rbusy  out  NRD  per-port scoreboard busy flag of ra[k].
REQ-009 we0, wa0, wd0  in  1/AW/XLEN  write port 0 (ALU writeback).
REQ-010 we1, wa1, wd1  in  1/AW/XLEN  write port 1 (load writeback).
REQ-011 set_en, set_addr  in  1/AW  mark destination register pending at issue.
REQ-012 dbg_addr  in  AW; dbg_data  out  XLEN  registered debug read.

Function
REQ-013 Register 0 SHALL read 0, never be written, never be busy.
REQ-014 Read port k SHALL return rf[ra[k]] combinationally (bypass per REQ-024).
REQ-015 Write port j SHALL update rf[waj] <= wdj on the clock edge when wej=1 and waj!=0.
REQ-016 Both ports writing one nonzero address same cycle: port 1 value SHALL be stored.
REQ-017 Busy bit b[a] SHALL set on edge when set_en=1, set_addr=a, a!=0.
REQ-018 Busy bit b[a] SHALL clear on edge when either write port writes a (a!=0).
REQ-019 Set and clear of same address same cycle: set SHALL win (b[a]=1 after edge).
REQ-020 rbusy[k] SHALL equal b[ra[k]] as registered (no same-cycle clear visibility), 0 for address 0.
REQ-021 dbg_data SHALL equal rf[dbg_addr] one cycle after dbg_addr is presented (value sampled pre-edge, no bypass).
REQ-022 Writes with wej=1 and waj=0 SHALL be silently discarded and SHALL NOT affect busy bits.

Reset
REQ-023 With rst=1 at an edge: all rf entries, all busy bits and dbg_data SHALL become 0; writes and set_en in that cycle SHALL be ignored; rd outputs follow the zeroed array the next cycle.

Configuration
REQ-024 Macro RF_BYPASS_EN defined: read port k whose nonzero ra[k] matches an active write SHALL return that write data (port 1 over port 0); rbusy[k] SHALL read 0 for that address that cycle unless set_en targets it.
REQ-025 RF_BYPASS_EN undefined: reads SHALL return pre-edge array contents; write visible the cycle after; rbusy unaffected by same-cycle writes.

Verification
REQ-026 rst=1 one cycle, then read all 32 addresses -> rd=0, rbusy=0, dbg_data=0.
REQ-027 we0=1, wa0=5, wd0=0xDEADBEEF; ra[0]=5 same cycle -> rd[0]=0xDEADBEEF with RF_BYPASS_EN, 0 without; next cycle 0xDEADBEEF both builds.
REQ-028 we0 wa0=7 wd0=0x11, we1 wa1=7 wd1=0x22 same cycle -> rf[7]=0x22 next cycle.
REQ-029 set_en addr 9 -> rbusy for ra=9 is 1 next cycle; we1 wa1=9 with set_en addr 9 same cycle -> stays 1; we1 wa1=9 alone -> 0 next cycle.
REQ-030 we0 wa0=0 wd0=0xFFFFFFFF and set_en addr 0 -> rd for ra=0 stays 0, rbusy 0.
REQ-031 write 0x55 to r3, then rst=1 concurrent with we0 wa0=3 wd0=0x99 -> rf[3]=0 after edge; dbg_addr=3 -> dbg_data=0 one cycle later.
